// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Bit counter must be able to hold SLOT_W itself (saturation value).
  function automatic int cnt_width(input int slot_w);
    return $clog2(slot_w + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Ready/valid stereo frame bus out of the I2S receiver.
interface i2s_rx_if #(
  parameter int SAMPLE_W = 16
);

  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_left;
  logic [SAMPLE_W-1:0] out_right;

  modport master (
    output out_valid,
    output out_left,
    output out_right,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_left,
    input  out_right,
    output out_ready
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a rising-edge strobe
// taken from the synchronized level (strobe is combinational off the flops).
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/lrclk/sdata, deserializes MSB-first and
// publishes {left,right} frames on a ready/valid bus with sticky error flags.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sclk,
  input  logic     lrclk,
  input  logic     sdata,
  input  logic     enable,
  input  logic     clear_err,
  i2s_rx_if.master out_if,
  output logic     overrun,
  output logic     frame_err
);

  localparam int                CNT_W      = cnt_width(SLOT_W);
  localparam logic [CNT_W-1:0]  SAMPLE_CNT = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0]  SLOT_CNT   = CNT_W'(SLOT_W);

  logic                   sclk_rise;
  logic                   sclk_lvl_unused;
  logic                   ws;
  logic                   ws_edge_unused;
  logic [SYNC_STAGES-1:0] sdata_q;
  logic                   bit_in;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(sclk),
    .sync_o (sclk_lvl_unused),
    .rise_o (sclk_rise)
  );

  // Word select is only consumed at sclk events, so its own edge strobe is spare.
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(lrclk),
    .sync_o (ws),
    .rise_o (ws_edge_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata_q <= '0;
    end else begin
      sdata_q <= {sdata_q[SYNC_STAGES-2:0], sdata};
    end
  end

  assign bit_in = sdata_q[SYNC_STAGES-1];

  i2s_rx_state_t       state_q;
  logic                ws_q;
  logic [SAMPLE_W-1:0] shifter_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [SAMPLE_W-1:0] left_hold_q;
  logic                out_valid_q;
  logic [SAMPLE_W-1:0] out_left_q;
  logic [SAMPLE_W-1:0] out_right_q;
  logic                overrun_q;
  logic                frame_err_q;

  logic                boundary;
  logic [SAMPLE_W-1:0] shift_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                slot_short;
  logic [SAMPLE_W-1:0] slot_val;

  // Slot value as it stands after the current event's bit has been absorbed.
  always_comb begin
    boundary   = sclk_rise && (ws != ws_q);
    shift_d    = shifter_q;
    cnt_d      = bit_cnt_q;
    if (sclk_rise && (bit_cnt_q < SAMPLE_CNT)) begin
      shift_d = {shifter_q[SAMPLE_W-2:0], bit_in};
    end
    if (sclk_rise && (bit_cnt_q != SLOT_CNT)) begin
      cnt_d = bit_cnt_q + 1'b1;
    end
    slot_short = (cnt_d < SAMPLE_CNT);
    slot_val   = slot_short ? (shift_d << (SAMPLE_CNT - cnt_d)) : shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ws_q        <= 1'b0;
      shifter_q   <= '0;
      bit_cnt_q   <= '0;
      left_hold_q <= '0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (out_valid_q && out_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (clear_err) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (sclk_rise) begin
        ws_q <= ws;
      end

      if (!enable) begin
        state_q   <= IDLE;
        shifter_q <= '0;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= SEEK;
          SEEK: begin
            if (boundary && (ws == CH_LEFT)) begin
              state_q   <= LEFT;
              shifter_q <= '0;
              bit_cnt_q <= '0;
            end
          end
          LEFT, RIGHT: begin
            if (boundary) begin
              shifter_q <= '0;
              bit_cnt_q <= '0;
              if ((state_q == LEFT) && (ws == CH_RIGHT)) begin
                left_hold_q <= slot_val;
                state_q     <= RIGHT;
                if (slot_short) frame_err_q <= 1'b1;
              end else if ((state_q == RIGHT) && (ws == CH_LEFT)) begin
                out_left_q  <= left_hold_q;
                out_right_q <= slot_val;
                out_valid_q <= 1'b1;
                // A same-cycle accept retires the old frame, so no overrun.
                if (out_valid_q && !out_if.out_ready) overrun_q <= 1'b1;
                if (slot_short) frame_err_q <= 1'b1;
                state_q     <= LEFT;
              end else begin
                state_q <= SEEK;
              end
            end else begin
              shifter_q <= shift_d;
              bit_cnt_q <= cnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_left  = out_left_q;
  assign out_if.out_right = out_right_q;
  assign overrun          = overrun_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: two instances (2- and 3-stage sync) share the pins.
module tb_i2s_rx;

  logic clk = 1'b0;
  logic rst;
  logic sclk;
  logic lrclk;
  logic sdata;
  logic enable;
  logic clear_err;
  logic overrun;
  logic frame_err;
  logic overrun3;
  logic frame_err3;

  int n_chk = 0;
  int n_err = 0;

  i2s_rx_if #(.SAMPLE_W(16)) bus  ();
  i2s_rx_if #(.SAMPLE_W(16)) bus3 ();

  i2s_rx #(.SAMPLE_W(16), .SLOT_W(32), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .enable   (enable),
    .clear_err(clear_err),
    .out_if   (bus.master),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  i2s_rx #(.SAMPLE_W(16), .SLOT_W(32), .SYNC_STAGES(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .enable   (enable),
    .clear_err(clear_err),
    .out_if   (bus3.master),
    .overrun  (overrun3),
    .frame_err(frame_err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w32(input logic [15:0] s);
    return {s, 16'hFFFF};
  endfunction

  // One sclk period of 8 clk cycles; mode 1 checks publish latency,
  // mode 2 raises out_ready exactly on the publish edge of the 2-stage DUT.
  task automatic send_bit(input logic ws, input logic b, input int mode);
    @(negedge clk);
    sclk  = 1'b0;
    lrclk = ws;
    sdata = b;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        if (k == 2) check("lat2_before", bus.out_valid, 32'd0);
        if (k == 3) check("lat2_edge", bus.out_valid, 32'd1);
        if (k == 3) check("lat3_before", bus3.out_valid, 32'd0);
        if (k == 4) check("lat3_edge", bus3.out_valid, 32'd1);
      end
      if (mode == 2 && k == 2) bus.out_ready = 1'b1;
      if (mode == 2 && k == 3) bus.out_ready = 1'b0;
    end
  endtask

  // Bits hi..lo of d, MSB first; bit 0 carries the flipped word select.
  task automatic send_range(input logic ws, input logic [31:0] d, input int hi,
                            input int lo, input int last_mode);
    for (int i = hi; i >= lo; i--) begin
      send_bit((i == 0) ? ~ws : ws, d[i], (i == 0) ? last_mode : 0);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input int mode);
    send_range(1'b0, l, n - 1, 0, 0);
    send_range(1'b1, r, n - 1, 0, mode);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    sclk           = 1'b0;
    lrclk          = 1'b0;
    sdata          = 1'b0;
    enable         = 1'b0;
    clear_err      = 1'b0;
    bus.out_ready  = 1'b0;
    bus3.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.out_valid, 32'd0);
    check("rst_left", bus.out_left, 32'd0);
    check("rst_right", bus.out_right, 32'd0);
    check("rst_overrun", overrun, 32'd0);
    check("rst_frame_err", frame_err, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // Sync slot then a standard frame with latency probes on the last bit.
    send_range(1'b1, 32'h0000_0000, 31, 0, 0);
    check("sync_no_publish", bus.out_valid, 32'd0);
    send_frame(w32(16'hA5C3), w32(16'h0F0F), 32, 1);
    check("std_valid", bus.out_valid, 32'd1);
    check("std_left", bus.out_left, 32'hA5C3);
    check("std_right", bus.out_right, 32'h0F0F);
    check("std_frame_err", frame_err, 32'd0);
    check("std_overrun", overrun, 32'd0);
    pulse_ready();
    check("std_consumed", bus.out_valid, 32'd0);

    // Short 12-bit slots.
    send_frame(32'h0000_0ABC, 32'h0000_0123, 12, 0);
    check("short_valid", bus.out_valid, 32'd1);
    check("short_left", bus.out_left, 32'hABC0);
    check("short_right", bus.out_right, 32'h1230);
    check("short_frame_err", frame_err, 32'd1);
    pulse_ready();
    pulse_clear();
    check("short_err_cleared", frame_err, 32'd0);

    // Overrun: two frames without consumption, newest wins.
    send_frame(w32(16'h1111), w32(16'h2222), 32, 0);
    send_frame(w32(16'h3333), w32(16'h4444), 32, 0);
    check("ovr_left", bus.out_left, 32'h3333);
    check("ovr_right", bus.out_right, 32'h4444);
    check("ovr_flag", overrun, 32'd1);
    check("ovr_valid", bus.out_valid, 32'd1);
    pulse_ready();
    check("ovr_consumed", bus.out_valid, 32'd0);
    pulse_clear();
    check("ovr_cleared", overrun, 32'd0);

    // Same-cycle accept of frame 1 while frame 2 publishes.
    send_frame(w32(16'h5555), w32(16'h6666), 32, 0);
    send_frame(w32(16'h7777), w32(16'h8888), 32, 2);
    check("same_valid", bus.out_valid, 32'd1);
    check("same_left", bus.out_left, 32'h7777);
    check("same_right", bus.out_right, 32'h8888);
    check("same_overrun", overrun, 32'd0);
    pulse_ready();

    // Enable drop during the right slot with a frame pending.
    send_frame(w32(16'hAAAA), w32(16'hBBBB), 32, 0);
    send_range(1'b0, w32(16'hCCCC), 31, 0, 0);
    send_range(1'b1, w32(16'h1234), 31, 22, 0);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("dis_valid_kept", bus.out_valid, 32'd1);
    check("dis_left_kept", bus.out_left, 32'hAAAA);
    enable = 1'b1;
    send_range(1'b1, w32(16'h1234), 21, 0, 0);
    check("dis_no_publish", bus.out_left, 32'hAAAA);
    check("dis_right_kept", bus.out_right, 32'hBBBB);
    pulse_ready();
    check("dis_consumed", bus.out_valid, 32'd0);
    send_frame(w32(16'hDDDD), w32(16'hEEEE), 32, 0);
    check("rec_left", bus.out_left, 32'hDDDD);
    check("rec_right", bus.out_right, 32'hEEEE);

    // Reset mid-slot with a frame pending.
    send_range(1'b0, w32(16'hFEED), 31, 24, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_valid", bus.out_valid, 32'd0);
    check("mrst_left", bus.out_left, 32'd0);
    check("mrst_right", bus.out_right, 32'd0);
    rst = 1'b0;
    send_range(1'b0, w32(16'hFEED), 23, 0, 0);
    send_range(1'b1, 32'h0000_0000, 31, 0, 0);
    check("mrst_no_publish", bus.out_valid, 32'd0);
    send_frame(w32(16'hFEED), w32(16'hBEEF), 32, 0);
    check("mrst_rec_valid", bus.out_valid, 32'd1);
    check("mrst_rec_left", bus.out_left, 32'hFEED);
    check("mrst_rec_right", bus.out_right, 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver for the audio path, e.g. a microphone/ADC feeding the game's sound or voice effects.
- The FPGA is the clock slave: external sclk/lrclk are oversampled in the clk domain and serial data is deserialized MSB-first.
- It assembles each stereo frame (left slot, then right slot) and presents it on a ready/valid output, with sticky overrun and short-slot flags.

Parameters:
- SAMPLE_W, 16, bits captured per channel, MSB-first; excess slot bits are ignored.
- SLOT_W, 32, maximum expected bits per slot; sizes the bit counter, which saturates at SLOT_W.
- SYNC_STAGES, 2, synchronizer depth applied identically to sclk, lrclk and sdata.

Ports:
- clk  in  1  system clock; must be at least 4x sclk.
- rst  in  1  reset, asynchronous, active-high.
- sclk  in  1  external I2S bit clock, asynchronous.
- lrclk  in  1  external word select; 0 = left, 1 = right; asynchronous.
- sdata  in  1  external serial data, asynchronous.
- enable  in  1  0 forces IDLE; 1 runs the receiver.
- out_ready  in  1  consumer accepts the frame when high together with out_valid.
- clear_err  in  1  single-cycle pulse clears overrun and frame_err.
- out_valid  out  1  a frame is pending.
- out_left  out  SAMPLE_W  left sample of the pending frame.
- out_right  out  SAMPLE_W  right sample of the pending frame.
- overrun  out  1  sticky: a frame completed while the previous frame was still unconsumed.
- frame_err  out  1  sticky: a slot held fewer than SAMPLE_W bits.

Behaviour:
- Reset: all outputs 0, state IDLE, shifter/counters 0, synchronizers 0.
- Synchronization and sampling:
  - sclk, lrclk and sdata each pass through SYNC_STAGES flops.
  - A sample event is a rising edge of synchronized sclk (sync output 1, previous 0).
  - At each sample event, ws = synced lrclk and bit = synced sdata; ws_q holds the ws of the previous sample event.
- Boundary: a sample event with ws != ws_q.
  - Per I2S one-bit delay, the boundary bit is the LSB-side last bit of the slot that is closing.
  - The new slot's MSB arrives at the next sample event.
- Slot capture:
  - At every sample event while in LEFT/RIGHT, including the boundary event: if bit_cnt < SAMPLE_W, shift the bit into shifter[SAMPLE_W-1:0] MSB-first. bit_cnt increments, saturating at SLOT_W.
  - At a boundary, after that bit is handled, the closing slot's value is taken. If bit_cnt < SAMPLE_W, the value is left-aligned with zeros in the missing LSBs and frame_err is set.
  - After the closing value is taken, shifter and bit_cnt are cleared.
- States:
  - IDLE: enable=1 -> SEEK.
  - SEEK: discard data; boundary with ws 1->0 -> LEFT, clearing shifter/bit_cnt.
  - LEFT: boundary 0->1 -> latch left_hold = slot value -> RIGHT.
  - RIGHT: boundary 1->0 -> publish frame {left_hold, slot value} -> LEFT.
  - Any state: enable=0 -> IDLE on the next clk. The partial frame is discarded; a pending output frame is retained until consumed.
  - A boundary arriving in a direction that does not match the state (glitch) -> SEEK, no publish.
- Publish:
  - Load out_left/out_right and set out_valid=1 on the clk edge after the detect cycle.
  - This is the (SYNC_STAGES+1)th clk edge counted from the first edge that samples the sclk pin high.
- Handshake:
  - out_valid && out_ready clears out_valid at the next edge; outputs stay stable while out_valid=1 and no publish occurs.
  - Publish with out_valid=1 and out_ready=0: the new frame overwrites (newest wins), out_valid stays 1, overrun set.
  - Publish in the same cycle as out_ready=1: the old frame is accepted, the new one is loaded, out_valid stays 1, no overrun.
- clear_err has lower priority than a same-cycle set: the flag remains 1.
- The first frame after reset or enable is never published until a full LEFT+RIGHT pass following SEEK.

Decomposition:
- Package i2s_pkg:
  - state enum i2s_rx_state_t {IDLE, SEEK, LEFT, RIGHT};
  - localparams CH_LEFT=1'b0, CH_RIGHT=1'b1;
  - a helper for the counter width, $clog2(SLOT_W+1).
- Sub-module i2s_sync_edge (param STAGES; in async_i; out sync_o, rise_o), instantiated for sclk and lrclk.
- sdata uses a plain STAGES-deep chain so all three signals are aligned.

Test Plan:
- Standard frame: SAMPLE_W=16, 32-bit slots, left=16'hA5C3, right=16'h0F0F, after one sync frame -> exactly one out_valid with out_left=A5C3, out_right=0F0F, frame_err=0.
- Short slots: 12-bit slots carrying left=12'hABC, right=12'h123 -> out_left=16'hABC0, out_right=16'h1230, frame_err=1; clear_err pulse -> 0.
- Overrun: hold out_ready=0 across frames 1111/2222 then 3333/4444 -> outputs 3333/4444, overrun=1, out_valid=1; ready pulse -> out_valid=0.
- Same-cycle accept: assert out_ready exactly on the publish cycle of frame 2 -> out_valid stays 1, frame 2 shown, overrun=0.
- Enable/reset mid-frame: drop enable during the RIGHT slot -> no publish for that frame, pending frame retained. Assert rst mid-slot -> all outputs 0. Recovery publishes only after SEEK plus a full frame.
- Latency/startup: SYNC_STAGES=3, clk=8x sclk -> first frame after enable is discarded; out_valid rises exactly 4 clk edges after the sclk-pin rise carrying the right-slot closing boundary bit.
